// File: rtl/demux.sv
// rtl/demux.sv - gated one-hot decoder of a binary select
module demux #(
    parameter int OUTPUT_WIDTH = 3,
    parameter int SEL_WIDTH    = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1
) (
    input  logic                    en_i,
    input  logic [SEL_WIDTH-1:0]    sel_i,
    output logic [OUTPUT_WIDTH-1:0] out_o
);

    // One bit per output; an out-of-range select or en_i low yields all-zero.
    always_comb begin
        out_o = '0;
        for (int i = 0; i < OUTPUT_WIDTH; i++) begin
            out_o[i] = en_i && (sel_i == SEL_WIDTH'(i));
        end
    end

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - packet-locked stream demultiplexer with drop counter
module stream_demux #(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNELS    = 3,
    parameter int COUNT_WIDTH = 8,
    localparam int SELECTOR_WIDTH = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_last,
    input  logic [SELECTOR_WIDTH-1:0] in_selector,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_last,
    output logic [COUNT_WIDTH-1:0]    drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    // One extra bit so the channel count itself is representable when CHANNELS is a power of two.
    localparam logic [SELECTOR_WIDTH:0] CH_LIMIT = (SELECTOR_WIDTH + 1)'(CHANNELS);

    state_t                    state_q, state_d;
    logic                      full_q, full_d;
    logic [SELECTOR_WIDTH-1:0] ch_q, ch_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      last_q, last_d;
    logic [COUNT_WIDTH-1:0]    drop_q, drop_d;

    logic sel_in_range;
    logic drain;
    logic route_ok;
    logic accept;

    demux #(
        .OUTPUT_WIDTH (CHANNELS),
        .SEL_WIDTH    (SELECTOR_WIDTH)
    ) u_valid_decode (
        .en_i  (full_q),
        .sel_i (ch_q),
        .out_o (out_valid)
    );

    assign sel_in_range = {1'b0, in_selector} < CH_LIMIT;
    // Only the held channel's ready can complete the output handshake.
    assign drain        = |(out_valid & out_ready);
    assign route_ok     = !full_q || drain;
    assign accept       = in_valid && in_ready;

    assign out_data   = data_q;
    assign out_last   = last_q;
    assign drop_count = drop_q;

    // Next-state, input ready, output register load and drop counting.
    always_comb begin
        state_d  = state_q;
        full_d   = full_q;
        ch_d     = ch_q;
        data_d   = data_q;
        last_d   = last_q;
        drop_d   = drop_q;
        in_ready = 1'b0;

        if (drain) begin
            full_d = 1'b0;
        end

        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (sel_in_range) begin
                        in_ready = route_ok;
                        if (in_valid && route_ok) begin
                            full_d = 1'b1;
                            ch_d   = in_selector;
                            data_d = in_data;
                            last_d = in_last;
                            if (!in_last) begin
                                state_d = ST_LOCKED;
                            end
                        end
                    end else begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            if (drop_q != '1) begin
                                drop_d = drop_q + 1'b1;
                            end
                            if (!in_last) begin
                                state_d = ST_DROP;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    in_ready = route_ok;
                    if (in_valid && route_ok) begin
                        full_d = 1'b1;
                        data_d = in_data;
                        last_d = in_last;
                        if (in_last) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    in_ready = 1'b1;
                    if (in_valid && in_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            full_q  <= 1'b0;
            ch_q    <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
        end
    end

endmodule
